// File: rtl/alu_ex_stage.sv
// Two-stage ALU execute stage: S1 operand register, combinational ALU, S2 result register.
// Valid/ready handshake on both sides, synchronous flush and a saturating overflow counter.

module alu #(
  parameter int W = 32
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic [2:0]   i_op,
  output logic [W-1:0] o_result,
  output logic         o_zero,
  output logic         o_carry,
  output logic         o_overflow
);

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SLTU = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_NOR  = 3'b101;
  localparam logic [2:0] OP_SUB  = 3'b110;
  localparam logic [2:0] OP_SLT  = 3'b111;

  logic         w_sub;
  logic         w_arith;
  logic         w_ovf;
  logic [W-1:0] w_bOp;
  logic [W:0]   w_sum;

  // SUB and SLT share the adder as A + ~B + 1; carry is the adder carry-out (1 means no borrow).
  always_comb begin
    w_sub   = (i_op == OP_SUB) || (i_op == OP_SLT);
    w_arith = w_sub || (i_op == OP_ADD);
    w_bOp   = w_sub ? ~i_b : i_b;
    w_sum   = {1'b0, i_a} + {1'b0, w_bOp} + {{W{1'b0}}, w_sub};
    w_ovf   = (i_a[W-1] == w_bOp[W-1]) && (w_sum[W-1] != i_a[W-1]);
  end

  always_comb begin
    o_result = '0;
    case (i_op)
      OP_AND:  o_result = i_a & i_b;
      OP_OR:   o_result = i_a | i_b;
      OP_ADD:  o_result = w_sum[W-1:0];
      OP_SLTU: o_result = {{(W-1){1'b0}}, (i_a < i_b)};
      OP_XOR:  o_result = i_a ^ i_b;
      OP_NOR:  o_result = ~(i_a | i_b);
      OP_SUB:  o_result = w_sum[W-1:0];
      OP_SLT:  o_result = {{(W-1){1'b0}}, (w_sum[W-1] ^ w_ovf)};
      default: o_result = '0;
    endcase
  end

  assign o_zero     = (o_result == '0);
  assign o_carry    = w_arith & w_sum[W];
  assign o_overflow = w_arith & w_ovf;

endmodule

module alu_ex_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_W      = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_A,
  input  logic [DATA_WIDTH-1:0] in_B,
  input  logic [2:0]            in_ALUop,
  input  logic [TAG_W-1:0]      in_tag,
  input  logic                  in_trap_en,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_result,
  output logic                  out_zero,
  output logic                  out_carry,
  output logic                  out_overflow,
  output logic [TAG_W-1:0]      out_tag,
  output logic                  out_trap,
  output logic [15:0]           ovf_count
);

  logic                  r_s1Valid;
  logic [DATA_WIDTH-1:0] r_s1A;
  logic [DATA_WIDTH-1:0] r_s1B;
  logic [2:0]            r_s1Op;
  logic [TAG_W-1:0]      r_s1Tag;
  logic                  r_s1TrapEn;

  logic                  r_s2Valid;
  logic [DATA_WIDTH-1:0] r_s2Result;
  logic                  r_s2Zero;
  logic                  r_s2Carry;
  logic                  r_s2Overflow;
  logic [TAG_W-1:0]      r_s2Tag;
  logic                  r_s2TrapEn;

  logic [15:0]           r_ovfCount;

  logic                  w_outXfer;
  logic                  w_s2Free;
  logic                  w_inXfer;
  logic                  w_advance;
  logic [DATA_WIDTH-1:0] w_aluResult;
  logic                  w_aluZero;
  logic                  w_aluCarry;
  logic                  w_aluOverflow;

  // S2 can take a new result when empty or draining this cycle, so a full pipe still streams.
  assign w_outXfer = r_s2Valid & out_ready;
  assign w_s2Free  = ~r_s2Valid | w_outXfer;
  assign in_ready  = ~flush & (~r_s1Valid | w_s2Free);
  assign w_inXfer  = in_valid & in_ready;
  assign w_advance = r_s1Valid & w_s2Free;

  alu #(
    .W (DATA_WIDTH)
  ) u_alu (
    .i_a        (r_s1A),
    .i_b        (r_s1B),
    .i_op       (r_s1Op),
    .o_result   (w_aluResult),
    .o_zero     (w_aluZero),
    .o_carry    (w_aluCarry),
    .o_overflow (w_aluOverflow)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1Valid  <= 1'b0;
      r_s1A      <= '0;
      r_s1B      <= '0;
      r_s1Op     <= '0;
      r_s1Tag    <= '0;
      r_s1TrapEn <= 1'b0;
    end else begin
      if (flush)
        r_s1Valid <= 1'b0;
      else if (w_inXfer)
        r_s1Valid <= 1'b1;
      else if (w_advance)
        r_s1Valid <= 1'b0;
      if (w_inXfer) begin
        r_s1A      <= in_A;
        r_s1B      <= in_B;
        r_s1Op     <= in_ALUop;
        r_s1Tag    <= in_tag;
        r_s1TrapEn <= in_trap_en;
      end
    end
  end

  // Data may load during a flush; only the valid bit matters for what downstream sees.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2Valid    <= 1'b0;
      r_s2Result   <= '0;
      r_s2Zero     <= 1'b0;
      r_s2Carry    <= 1'b0;
      r_s2Overflow <= 1'b0;
      r_s2Tag      <= '0;
      r_s2TrapEn   <= 1'b0;
    end else begin
      if (flush)
        r_s2Valid <= 1'b0;
      else if (w_advance)
        r_s2Valid <= 1'b1;
      else if (w_outXfer)
        r_s2Valid <= 1'b0;
      if (w_advance) begin
        r_s2Result   <= w_aluResult;
        r_s2Zero     <= w_aluZero;
        r_s2Carry    <= w_aluCarry;
        r_s2Overflow <= w_aluOverflow;
        r_s2Tag      <= r_s1Tag;
        r_s2TrapEn   <= r_s1TrapEn;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_ovfCount <= 16'd0;
    else if (w_outXfer && !flush && r_s2Overflow && (r_ovfCount != 16'hFFFF))
      r_ovfCount <= r_ovfCount + 16'd1;
  end

  assign out_valid    = r_s2Valid;
  assign out_result   = r_s2Result;
  assign out_zero     = r_s2Zero;
  assign out_carry    = r_s2Carry;
  assign out_overflow = r_s2Overflow;
  assign out_tag      = r_s2Tag;
  assign out_trap     = r_s2Valid & r_s2Overflow & r_s2TrapEn;
  assign ovf_count    = r_ovfCount;

endmodule

// File: tb/tb_alu_ex_stage.sv
// Directed bench for alu_ex_stage: a reference model fills a scoreboard queue on each accepted
// operation, and every delivered result is popped and compared, with directed checks in between.

module tb_alu_ex_stage;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SLTU = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_NOR  = 3'b101;
  localparam logic [2:0] OP_SUB  = 3'b110;
  localparam logic [2:0] OP_SLT  = 3'b111;

  typedef struct packed {
    logic [31:0] res;
    logic        z;
    logic        c;
    logic        v;
    logic [4:0]  tag;
    logic        trap;
  } res_t;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_A;
  logic [31:0] in_B;
  logic [2:0]  in_ALUop;
  logic [4:0]  in_tag;
  logic        in_trap_en;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_zero;
  logic        out_carry;
  logic        out_overflow;
  logic [4:0]  out_tag;
  logic        out_trap;
  logic [15:0] ovf_count;

  int          checks;
  int          errors;
  int          delivered;
  logic        lastAccepted;
  logic [15:0] expOvf;
  res_t        sbQ[$];

  alu_ex_stage #(
    .DATA_WIDTH (32),
    .TAG_W      (5)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_A         (in_A),
    .in_B         (in_B),
    .in_ALUop     (in_ALUop),
    .in_tag       (in_tag),
    .in_trap_en   (in_trap_en),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_zero     (out_zero),
    .out_carry    (out_carry),
    .out_overflow (out_overflow),
    .out_tag      (out_tag),
    .out_trap     (out_trap),
    .ovf_count    (ovf_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference ALU; SUB/SLT carry means "no borrow", i.e. A >= B unsigned.
  function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                                 input logic [4:0] tag, input logic trapEn);
    res_t        r;
    logic [32:0] full;
    r     = '0;
    r.tag = tag;
    case (op)
      OP_AND:  r.res = a & b;
      OP_OR:   r.res = a | b;
      OP_ADD: begin
        full  = {1'b0, a} + {1'b0, b};
        r.res = full[31:0];
        r.c   = full[32];
        r.v   = (a[31] == b[31]) && (r.res[31] != a[31]);
      end
      OP_SLTU: r.res = (a < b) ? 32'd1 : 32'd0;
      OP_XOR:  r.res = a ^ b;
      OP_NOR:  r.res = ~(a | b);
      OP_SUB: begin
        r.res = a - b;
        r.c   = (a >= b);
        r.v   = (a[31] != b[31]) && (r.res[31] != a[31]);
      end
      default: begin
        full  = {1'b0, a - b};
        r.c   = (a >= b);
        r.v   = (a[31] != b[31]) && (full[31] != a[31]);
        r.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      end
    endcase
    r.z    = (r.res == 32'd0);
    r.trap = r.v & trapEn;
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] obs, input logic [63:0] expV);
    checks++;
    assert (obs === expV)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", name, obs, expV);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                               input logic [4:0] tag, input logic trapEn);
    in_valid   = 1'b1;
    in_A       = a;
    in_B       = b;
    in_ALUop   = op;
    in_tag     = tag;
    in_trap_en = trapEn;
  endtask

  task automatic idleInput();
    in_valid = 1'b0;
  endtask

  // One clock: scoreboard work at the falling edge, then return 1 time unit after the rising edge.
  task automatic tick();
    res_t obsV;
    res_t expV;
    @(negedge clk);
    lastAccepted = 1'b0;
    if (!rst) begin
      checkOutput("ovf_count", 64'(ovf_count), 64'(expOvf));
      if (!out_valid) checkOutput("trap_idle", 64'(out_trap), 64'(0));
      if (flush) begin
        sbQ.delete();
      end else begin
        if (out_valid && out_ready) begin
          checkOutput("sb_pending", 64'(sbQ.size() > 0), 64'(1));
          if (sbQ.size() > 0) begin
            expV = sbQ.pop_front();
            obsV = {out_result, out_zero, out_carry, out_overflow, out_tag, out_trap};
            checkOutput("result", 64'(obsV), 64'(expV));
            delivered++;
            if (expV.v && expOvf != 16'hFFFF) expOvf = expOvf + 16'd1;
          end
        end
        if (in_valid && in_ready) begin
          sbQ.push_back(model(in_A, in_B, in_ALUop, in_tag, in_trap_en));
          lastAccepted = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    idleInput();
    while (sbQ.size() > 0 && guard < 50) begin
      tick();
      guard++;
    end
    checkOutput("drain_left", 64'(sbQ.size()), 64'(0));
  endtask

  initial begin
    int          idx;
    int          deliveredBefore;
    int          satCycles;
    logic [15:0] ovfBefore;
    logic [31:0] opsA[3];
    logic [2:0]  opsOp[3];

    checks       = 0;
    errors       = 0;
    delivered    = 0;
    expOvf       = 16'd0;
    lastAccepted = 1'b0;
    rst          = 1'b1;
    flush        = 1'b0;
    out_ready    = 1'b1;
    in_valid     = 1'b0;
    in_A         = '0;
    in_B         = '0;
    in_ALUop     = '0;
    in_tag       = '0;
    in_trap_en   = 1'b0;

    // Reset state, then in_ready on the first cycle after release
    #3;
    checkOutput("rst_out_valid", 64'(out_valid), 64'(0));
    checkOutput("rst_out_trap", 64'(out_trap), 64'(0));
    checkOutput("rst_ovf_count", 64'(ovf_count), 64'(0));
    checkOutput("rst_out_result", 64'(out_result), 64'(0));
    checkOutput("rst_out_tag", 64'(out_tag), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("post_rst_in_ready", 64'(in_ready), 64'(1));

    // Overflowing ADD with trap enabled, two cycles of latency
    applyStimulus(32'h7FFF_FFFF, 32'd1, OP_ADD, 5'd9, 1'b1);
    tick();
    idleInput();
    checkOutput("add_lat1_valid", 64'(out_valid), 64'(0));
    tick();
    checkOutput("add_valid", 64'(out_valid), 64'(1));
    checkOutput("add_result", 64'(out_result), 64'h8000_0000);
    checkOutput("add_overflow", 64'(out_overflow), 64'(1));
    checkOutput("add_trap", 64'(out_trap), 64'(1));
    tick();
    checkOutput("add_ovf_count", 64'(ovf_count), 64'(1));
    checkOutput("add_done_valid", 64'(out_valid), 64'(0));

    // Back-to-back SUB, SLT, SLTU
    applyStimulus(32'd5, 32'd5, OP_SUB, 5'd1, 1'b0);
    tick();
    applyStimulus(32'hFFFF_FFFF, 32'd1, OP_SLT, 5'd2, 1'b0);
    tick();
    checkOutput("b2b_tag1", 64'(out_tag), 64'(1));
    checkOutput("b2b_res1", 64'(out_result), 64'(0));
    checkOutput("b2b_zero1", 64'(out_zero), 64'(1));
    applyStimulus(32'd1, 32'd2, OP_SLTU, 5'd3, 1'b0);
    tick();
    checkOutput("b2b_tag2", 64'(out_tag), 64'(2));
    checkOutput("b2b_res2", 64'(out_result), 64'(1));
    idleInput();
    tick();
    checkOutput("b2b_tag3", 64'(out_tag), 64'(3));
    checkOutput("b2b_res3", 64'(out_result), 64'(1));
    tick();
    checkOutput("b2b_empty", 64'(out_valid), 64'(0));

    // Backpressure: three ops offered over five stalled cycles
    opsA[0] = 32'h0000_F0F0; opsOp[0] = OP_AND;
    opsA[1] = 32'h1234_0000; opsOp[1] = OP_OR;
    opsA[2] = 32'hFFFF_0000; opsOp[2] = OP_XOR;
    out_ready = 1'b0;
    idx = 0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(opsA[idx], 32'h0000_FF00, opsOp[idx], 5'(4 + idx), 1'b0);
      tick();
      if (lastAccepted) idx++;
    end
    checkOutput("bp_accepted", 64'(idx), 64'(2));
    checkOutput("bp_in_ready", 64'(in_ready), 64'(0));
    checkOutput("bp_out_valid", 64'(out_valid), 64'(1));
    checkOutput("bp_hold_tag", 64'(out_tag), 64'(4));
    checkOutput("bp_hold_result", 64'(out_result), 64'h0000_F000);
    deliveredBefore = delivered;
    out_ready = 1'b1;
    for (int i = 0; i < 10 && idx < 3; i++) begin
      applyStimulus(opsA[idx], 32'h0000_FF00, opsOp[idx], 5'(4 + idx), 1'b0);
      tick();
      if (lastAccepted) idx++;
    end
    drain();
    checkOutput("bp_delivered", 64'(delivered - deliveredBefore), 64'(3));

    // Flush with both stages full and a new op offered
    out_ready = 1'b0;
    applyStimulus(32'h7FFF_FFFF, 32'd1, OP_ADD, 5'd10, 1'b1);
    tick();
    applyStimulus(32'h7FFF_FFFF, 32'd2, OP_ADD, 5'd11, 1'b1);
    tick();
    checkOutput("fl_pre_valid", 64'(out_valid), 64'(1));
    applyStimulus(32'd1, 32'd1, OP_ADD, 5'd12, 1'b0);
    out_ready = 1'b1;
    flush     = 1'b1;
    ovfBefore = ovf_count;
    checkOutput("fl_in_ready", 64'(in_ready), 64'(0));
    tick();
    flush = 1'b0;
    idleInput();
    checkOutput("fl_out_valid", 64'(out_valid), 64'(0));
    checkOutput("fl_ovf_same", 64'(ovf_count), 64'(ovfBefore));
    tick();
    tick();
    checkOutput("fl_nothing_accepted", 64'(out_valid), 64'(0));

    // Mixed traffic with random backpressure
    for (int i = 0; i < 60; i++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      in_A       = $urandom;
      in_B       = (i % 3 == 0) ? in_A : $urandom;
      in_ALUop   = 3'($urandom_range(0, 7));
      in_tag     = 5'(i);
      in_trap_en = 1'($urandom_range(0, 1));
      out_ready  = ($urandom_range(0, 3) != 0);
      tick();
    end
    out_ready = 1'b1;
    drain();

    // Saturate ovf_count, then one more overflowing ADD
    satCycles = 0;
    while (expOvf != 16'hFFFF && satCycles < 70000) begin
      applyStimulus(32'h7FFF_FFFF, 32'd1, OP_ADD, 5'(satCycles), 1'b0);
      tick();
      satCycles++;
    end
    checkOutput("sat_reached", 64'(ovf_count), 64'hFFFF);
    applyStimulus(32'h8000_0000, 32'h8000_0000, OP_ADD, 5'd30, 1'b1);
    tick();
    drain();
    checkOutput("sat_hold", 64'(ovf_count), 64'hFFFF);

    // Asynchronous reset between edges with S2 full
    out_ready = 1'b0;
    applyStimulus(32'd3, 32'd4, OP_OR, 5'd7, 1'b0);
    tick();
    idleInput();
    tick();
    checkOutput("ar_pre_valid", 64'(out_valid), 64'(1));
    #2;
    rst = 1'b1;
    #1;
    checkOutput("ar_out_valid", 64'(out_valid), 64'(0));
    checkOutput("ar_ovf_count", 64'(ovf_count), 64'(0));
    checkOutput("ar_out_result", 64'(out_result), 64'(0));
    sbQ.delete();
    expOvf = 16'd0;
    #1;
    rst = 1'b0;
    checkOutput("ar_in_ready", 64'(in_ready), 64'(1));
    out_ready = 1'b1;
    tick();
    tick();
    checkOutput("ar_dropped", 64'(out_valid), 64'(0));
    applyStimulus(32'd2, 32'd3, OP_ADD, 5'd21, 1'b1);
    tick();
    idleInput();
    tick();
    checkOutput("ar_after_valid", 64'(out_valid), 64'(1));
    checkOutput("ar_after_result", 64'(out_result), 64'(5));
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_ex_stage.md
ALU_EX_STAGE -- requirements
Module: alu_ex_stage

Interface
REQ-001 Parameter DATA_WIDTH, default 32: operand/result width.
REQ-002 Parameter TAG_W, default 5: destination-tag width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 flush  input  1  synchronous; discards all in-flight operations.
REQ-006 in_valid  input  1  upstream operation valid.
REQ-007 in_ready  output  1  stage can accept an operation this cycle.
REQ-008 in_A  input  DATA_WIDTH  operand A.
REQ-009 in_B  input  DATA_WIDTH  operand B.
REQ-010 in_ALUop  input  3  ALU opcode: 000 AND, 001 OR, 010 ADD, 011 SLTU, 100 XOR, 101 NOR, 110 SUB, 111 SLT.
REQ-011 in_tag  input  TAG_W  destination tag, carried through unchanged.
REQ-012 in_trap_en  input  1  overflow trap enable for this operation.
REQ-013 out_valid  output  1  result valid to downstream.
REQ-014 out_ready  input  1  downstream accepts the result.
REQ-015 out_result  output  DATA_WIDTH  ALU Result.
REQ-016 out_zero, out_carry, out_overflow  output  1 each  ALU Zero, CarryOut, Overflow flags.
REQ-017 out_tag  output  TAG_W  tag of the operation presented.
REQ-018 out_trap  output  1  out_overflow AND the operation's captured trap enable.
REQ-019 ovf_count  output  16  saturating count of delivered operations with overflow.

Function
REQ-020 The block SHALL be a two-stage pipeline: S1 operand register, S2 result register; the existing alu block SHALL be instantiated combinationally between S1 and S2.
REQ-021 Input transfer SHALL occur when in_valid AND in_ready; output transfer when out_valid AND out_ready.
REQ-022 S2 SHALL be loadable (s2_free) when S2 is empty or an output transfer occurs this cycle.
REQ-023 in_ready SHALL equal NOT flush AND (S1 empty OR (S1 full AND s2_free)); purely combinational, no dependency on in_valid.
REQ-024 When S1 is full and s2_free, S2 SHALL capture ALU Result, Zero, CarryOut, Overflow, tag and trap_en from S1 at the next edge.
REQ-025 Latency SHALL be exactly 2 cycles from input transfer to out_valid with out_ready held high; sustained throughput one operation per cycle.
REQ-026 With out_ready low, S2 SHALL hold all outputs stable while out_valid is high; S1 SHALL then fill and in_ready SHALL drop; no operation is lost or duplicated.
REQ-027 Simultaneous output transfer and S1-to-S2 advance SHALL replace S2 contents in the same edge (no bubble).
REQ-028 Operations SHALL leave in acceptance order.
REQ-029 flush SHALL clear S1 and S2 valid bits at the next edge, overriding any same-cycle input or output transfer; data registers need not clear; ovf_count SHALL not increment for a result whose transfer coincides with flush.
REQ-030 ovf_count SHALL increment by 1 on each output transfer with out_overflow=1 and SHALL saturate at 16'hFFFF.
REQ-031 Overflow/CarryOut semantics SHALL be those of the alu block (valid only for ADD, SUB, SLT; zero for other ops).
REQ-032 out_* data outputs SHALL be don't-care while out_valid=0, except out_trap which SHALL be 0 when out_valid=0.

Reset
REQ-033 On rst assertion, immediately and asynchronously: S1/S2 valid=0, out_valid=0, out_trap=0, ovf_count=0; out_result, out_tag and flags SHALL reset to 0.
REQ-034 After rst deasserts, in_ready SHALL be 1 in the first cycle (absent flush).
REQ-035 rst mid-operation SHALL drop all in-flight operations without emitting them.

Verification
REQ-036 ADD A=32'h7FFFFFFF, B=1, trap_en=1, out_ready=1 -> 2 cycles later out_result=32'h80000000, out_overflow=1, out_trap=1, ovf_count=1.
REQ-037 Back-to-back SUB 5-5, SLT 32'hFFFFFFFF vs 1, SLTU 1 vs 2 with tags 1,2,3 -> results 0/zero=1, 1, 1 on consecutive cycles, tags 1,2,3 in order.
REQ-038 out_ready=0 for 5 cycles while 3 ops offered -> 2 accepted, in_ready=0, outputs stable; release -> 3 results delivered in order, none lost.
REQ-039 flush asserted with S1 and S2 full and in_valid=1 -> next cycle out_valid=0, nothing accepted, ovf_count unchanged.
REQ-040 Preload ovf_count to 16'hFFFF via 65535 overflowing ADDs, then one more -> ovf_count stays 16'hFFFF.
REQ-041 rst pulsed asynchronously between clock edges with S2 full -> out_valid and ovf_count go 0 before next edge; first post-reset cycle in_ready=1.
